// File: rtl/stream_slave_pkg.sv
// Shared types for the stream capture slave: runtime modes, FSM states and count widths.
package stream_slave_pkg;

    typedef enum logic [1:0] {
        MODE_BLOCK   = 2'b00,
        MODE_SINK    = 2'b01,
        MODE_CAPTURE = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StSink,
        StCapture,
        StDone
    } state_t;

    localparam int unsigned PKT_COUNT_WIDTH = 16;

    // Mode 2'b11 is not a member of mode_t and falls back to blocking.
    function automatic state_t start_state(logic [1:0] mode);
        case (mode)
            MODE_SINK:    return StSink;
            MODE_CAPTURE: return StCapture;
            default:      return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/stream_capture_slave_if.sv
// AXI-Stream beat channel between a stream source (master) and the capture slave.
interface stream_capture_slave_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/stream_slave_ram.sv
// Simple dual-port RAM: one write port, one registered read port; the array itself is not reset.
module stream_slave_ram #(
    parameter int unsigned WIDTH     = 36,
    parameter int unsigned IDX_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [IDX_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [IDX_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read-during-write to the same address returns the previous content.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_capture_slave.sv
// AXI-Stream slave endpoint with block / sink / capture modes and synchronous buffer readback.
// Optional STREAM_SLAVE_KEEP_MASK_EN: bytes with TKEEP=0 are stored as 8'h00.
module stream_capture_slave
    import stream_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned STORAGE_IDX_WIDTH = 10,
    parameter bit          DROP_WHEN_FULL    = 1'b0,
    parameter bit          STOP_ON_LAST      = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    stream_capture_slave_if.slave        s_axi,
    input  logic [1:0]                   cfg_mode,
    input  logic                         cfg_start,
    input  logic                         rd_en,
    input  logic [STORAGE_IDX_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [DATA_WIDTH/8-1:0]      rd_keep,
    output logic [STORAGE_IDX_WIDTH:0]   word_count,
    output logic [PKT_COUNT_WIDTH-1:0]   pkt_count,
    output logic                         done,
    output logic                         overflow
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned WC_WIDTH   = STORAGE_IDX_WIDTH + 1;
    localparam int unsigned RAM_WIDTH  = DATA_WIDTH + KEEP_WIDTH;
    localparam logic [WC_WIDTH-1:0] DEPTH = {1'b1, {STORAGE_IDX_WIDTH{1'b0}}};

    state_t                     state_q, state_d;
    logic [WC_WIDTH-1:0]        wc_q, wc_d;
    logic [PKT_COUNT_WIDTH-1:0] pkt_q, pkt_d;
    logic                       ovf_q, ovf_d;
    logic                       tready;
    logic                       accept;
    logic                       wr_en;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic [RAM_WIDTH-1:0]       rd_word;

    // Ready is a pure state decode so it never combinationally follows TVALID.
    assign tready = (state_q == StSink) || (state_q == StCapture) ||
                    ((state_q == StDone) && DROP_WHEN_FULL);
    assign s_axi.tready = tready;
    assign accept = s_axi.tvalid && tready;

`ifdef STREAM_SLAVE_KEEP_MASK_EN
    always_comb begin
        wr_data = '0;
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            wr_data[b*8 +: 8] = s_axi.tkeep[b] ? s_axi.tdata[b*8 +: 8] : 8'h00;
        end
    end
`else
    assign wr_data = s_axi.tdata;
`endif

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        pkt_d   = pkt_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        // A restart wins over a coincident beat: that beat is neither stored nor counted.
        if (cfg_start) begin
            state_d = start_state(cfg_mode);
            wc_d    = '0;
            pkt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            unique case (state_q)
                StSink: begin
                    if (s_axi.tlast) pkt_d = pkt_q + 1'b1;
                end
                StCapture: begin
                    wr_en = 1'b1;
                    wc_d  = wc_q + 1'b1;
                    if (s_axi.tlast) pkt_d = pkt_q + 1'b1;
                    if ((s_axi.tlast && STOP_ON_LAST) || (wc_d == DEPTH)) state_d = StDone;
                end
                StDone: begin
                    ovf_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            wc_q    <= '0;
            pkt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            pkt_q   <= pkt_d;
            ovf_q   <= ovf_d;
        end
    end

    stream_slave_ram #(
        .WIDTH     (RAM_WIDTH),
        .IDX_WIDTH (STORAGE_IDX_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en),
        .waddr_i (wc_q[STORAGE_IDX_WIDTH-1:0]),
        .wdata_i ({s_axi.tkeep, wr_data}),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_word)
    );

    assign rd_data    = rd_word[DATA_WIDTH-1:0];
    assign rd_keep    = rd_word[RAM_WIDTH-1:DATA_WIDTH];
    assign word_count = wc_q;
    assign pkt_count  = pkt_q;
    assign done       = (state_q == StDone);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stream_capture_slave.sv
// Randomized bench for stream_capture_slave: two instances (backpressure/stop-on-last and
// drop-when-full/no-stop) checked against a queue-free behavioural model of the capture buffer.
module tb_stream_capture_slave;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int IW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] tdata [2];
    logic [KW-1:0] tkeep [2];
    logic          tvalid[2];
    logic          tlast [2];
    logic          tready[2];
    logic [1:0]    cfg_mode [2];
    logic          cfg_start[2];
    logic          rd_en    [2];
    logic [IW-1:0] rd_addr  [2];
    logic [DW-1:0] rd_data  [2];
    logic [KW-1:0] rd_keep  [2];
    logic [IW:0]   word_count[2];
    logic [15:0]   pkt_count [2];
    logic          done      [2];
    logic          overflow  [2];

    stream_capture_slave_if #(.DATA_WIDTH(DW)) if_a ();
    stream_capture_slave_if #(.DATA_WIDTH(DW)) if_b ();

    assign if_a.tdata  = tdata[0];
    assign if_a.tkeep  = tkeep[0];
    assign if_a.tvalid = tvalid[0];
    assign if_a.tlast  = tlast[0];
    assign tready[0]   = if_a.tready;
    assign if_b.tdata  = tdata[1];
    assign if_b.tkeep  = tkeep[1];
    assign if_b.tvalid = tvalid[1];
    assign if_b.tlast  = tlast[1];
    assign tready[1]   = if_b.tready;

    stream_capture_slave #(
        .DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IW), .DROP_WHEN_FULL(1'b0), .STOP_ON_LAST(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .s_axi(if_a),
        .cfg_mode(cfg_mode[0]), .cfg_start(cfg_start[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .rd_keep(rd_keep[0]), .word_count(word_count[0]),
        .pkt_count(pkt_count[0]), .done(done[0]), .overflow(overflow[0])
    );

    stream_capture_slave #(
        .DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IW), .DROP_WHEN_FULL(1'b1), .STOP_ON_LAST(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .s_axi(if_b),
        .cfg_mode(cfg_mode[1]), .cfg_start(cfg_start[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .rd_keep(rd_keep[1]), .word_count(word_count[1]),
        .pkt_count(pkt_count[1]), .done(done[1]), .overflow(overflow[1])
    );

    int checks = 0;
    int failures = 0;

    // Reference model: what a capture buffer should hold, derived from the beat rules.
    int  cur;
    int  m_mode;      // 0 block, 1 sink, 2 capture
    int  m_words;
    int  m_pkts;
    bit  m_done, m_ovf, m_drop, m_stop;
    logic [KW+DW-1:0] m_ram[2][DEPTH];

    function automatic logic [DW-1:0] stored_data(logic [DW-1:0] d, logic [KW-1:0] k);
        logic [KW-1:0] mk = k;
        logic [DW-1:0] r = d;
`ifndef STREAM_SLAVE_KEEP_MASK_EN
        mk = '1;
`endif
        for (int b = 0; b < KW; b++) if (!mk[b]) r[b*8 +: 8] = 8'h00;
        return r;
    endfunction

    function automatic void m_select(int d);
        cur    = d;
        m_drop = (d == 1);
        m_stop = (d == 0);
    endfunction

    function automatic void m_clear(int mode);
        m_mode  = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
        m_words = 0;
        m_pkts  = 0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic bit m_ready();
        return (m_mode == 1) || ((m_mode == 2) && (!m_done || m_drop));
    endfunction

    function automatic void m_beat(logic [DW-1:0] d, logic [KW-1:0] k, bit l);
        if (!m_ready()) return;
        if (m_mode == 1) begin
            if (l) m_pkts = (m_pkts + 1) % 65536;
        end else if (m_done) begin
            m_ovf = 1'b1;
        end else begin
            m_ram[cur][m_words] = {k, stored_data(d, k)};
            m_words++;
            if (l) m_pkts = (m_pkts + 1) % 65536;
            if ((l && m_stop) || (m_words == DEPTH)) m_done = 1'b1;
        end
    endfunction

    task automatic do_start(int d, logic [1:0] mode);
        @(negedge clk);
        cfg_mode[d]  = mode;
        cfg_start[d] = 1'b1;
        @(posedge clk);
        m_clear(int'(mode));
        @(negedge clk);
        cfg_start[d] = 1'b0;
    endtask

    task automatic beat_step(input int d, input bit v, input logic [DW-1:0] dat,
                             input logic [KW-1:0] k, input bit l,
                             output logic obs_rdy, output bit exp_rdy);
        @(negedge clk);
        tvalid[d] = v;
        tdata[d]  = dat;
        tkeep[d]  = k;
        tlast[d]  = l;
        obs_rdy   = tready[d];
        exp_rdy   = m_ready();
        @(posedge clk);
        if (v) m_beat(dat, k, l);
    endtask

    task automatic do_read(int d, int addr);
        @(negedge clk);
        tvalid[d]  = 1'b0;
        rd_en[d]   = 1'b1;
        rd_addr[d] = addr[IW-1:0];
        @(posedge clk);
        @(negedge clk);
        rd_en[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tvalid[d] = 1'b1; tdata[d] = 32'h1234_5678; tkeep[d] = '1; tlast[d] = 1'b0;
            cfg_mode[d] = 2'b00; cfg_start[d] = 1'b0; rd_en[d] = 1'b0; rd_addr[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_clear(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (tready[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_tready dut=%0d got=%b exp=0", d, tready[d]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({word_count[d], pkt_count[d], done[d], overflow[d], rd_data[d], rd_keep[d]} !== '0)
            begin
                failures++;
                $display("FAIL reset_outputs dut=%0d wc=%0d pkt=%0d done=%b ovf=%b rd=%h exp all 0",
                         d, word_count[d], pkt_count[d], done[d], overflow[d], rd_data[d]);
            end
            tvalid[d] = 1'b0;
        end
    endtask

    task automatic test_capture_basic();
        logic obs;
        bit   exp;
        m_select(0);
        do_start(0, 2'b10);
        for (int i = 0; i < 4; i++) begin
            beat_step(0, 1'b1, 32'hA0 + i, 4'hF, (i == 2), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL basic_tready beat=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        @(negedge clk);
        tvalid[0] = 1'b0;
        checks++;
        if (done[0] !== m_done || word_count[0] !== m_words[IW:0] || pkt_count[0] !== m_pkts[15:0])
        begin
            failures++;
            $display("FAIL basic_status done=%b wc=%0d pkt=%0d exp done=%b wc=%0d pkt=%0d",
                     done[0], word_count[0], pkt_count[0], m_done, m_words, m_pkts);
        end
        do_read(0, 2);
        checks++;
        if (rd_data[0] !== m_ram[0][2][DW-1:0]) begin
            failures++;
            $display("FAIL basic_read got=%h exp=%h", rd_data[0], m_ram[0][2][DW-1:0]);
        end
        @(negedge clk);
        rd_addr[0] = 4'd0;
        @(negedge clk);
        checks++;
        if (rd_data[0] !== m_ram[0][2][DW-1:0]) begin
            failures++;
            $display("FAIL read_hold got=%h exp=%h", rd_data[0], m_ram[0][2][DW-1:0]);
        end
    endtask

    task automatic test_capture_random();
        logic obs;
        bit   exp;
        m_select(0);
        do_start(0, 2'b10);
        for (int i = 0; i < 30; i++) begin
            beat_step(0, ($urandom_range(0, 9) < 7), $urandom, 4'($urandom),
                      ($urandom_range(0, 7) == 0), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rand_tready cycle=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        @(negedge clk);
        tvalid[0] = 1'b0;
        checks++;
        if (done[0] !== m_done || word_count[0] !== m_words[IW:0] || pkt_count[0] !== m_pkts[15:0])
        begin
            failures++;
            $display("FAIL rand_status done=%b wc=%0d pkt=%0d exp done=%b wc=%0d pkt=%0d",
                     done[0], word_count[0], pkt_count[0], m_done, m_words, m_pkts);
        end
        for (int a = 0; a < m_words; a++) begin
            do_read(0, a);
            checks++;
            if ({rd_keep[0], rd_data[0]} !== m_ram[0][a]) begin
                failures++;
                $display("FAIL rand_read addr=%0d got=%h exp=%h", a, {rd_keep[0], rd_data[0]},
                         m_ram[0][a]);
            end
        end
    endtask

    task automatic test_drop_full();
        logic obs;
        bit   exp;
        m_select(1);
        do_start(1, 2'b10);
        for (int i = 0; i < 20; i++) begin
            beat_step(1, 1'b1, 32'hB00 + i, 4'($urandom), ($urandom_range(0, 3) == 0), obs, exp);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL drop_tready beat=%0d got=%b exp=%b", i, obs, exp);
            end
        end
        @(negedge clk);
        tvalid[1] = 1'b0;
        checks++;
        if (word_count[1] !== m_words[IW:0] || done[1] !== m_done || overflow[1] !== m_ovf ||
            pkt_count[1] !== m_pkts[15:0]) begin
            failures++;
            $display("FAIL drop_status wc=%0d done=%b ovf=%b pkt=%0d exp wc=%0d done=%b ovf=%b pkt=%0d",
                     word_count[1], done[1], overflow[1], pkt_count[1], m_words, m_done, m_ovf,
                     m_pkts);
        end
        checks++;
        if (tready[1] !== 1'b1) begin
            failures++;
            $display("FAIL drop_tready_after got=%b exp=1", tready[1]);
        end
        do_read(1, 15);
        checks++;
        if ({rd_keep[1], rd_data[1]} !== m_ram[1][15]) begin
            failures++;
            $display("FAIL drop_read15 got=%h exp=%h", {rd_keep[1], rd_data[1]}, m_ram[1][15]);
        end
    endtask

    task automatic test_sink();
        logic obs;
        bit   exp;
        m_select(0);
        do_start(0, 2'b01);
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 2)) beat_step(0, 1'b0, '0, '0, 1'b0, obs, exp);
                beat_step(0, 1'b1, $urandom, 4'hF, (b == 3), obs, exp);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL sink_tready pkt=%0d beat=%0d got=%b exp=%b", p, b, obs, exp);
                end
            end
        end
        @(negedge clk);
        tvalid[0] = 1'b0;
        checks++;
        if (pkt_count[0] !== m_pkts[15:0] || word_count[0] !== m_words[IW:0] || done[0] !== 1'b0)
        begin
            failures++;
            $display("FAIL sink_status pkt=%0d wc=%0d done=%b exp pkt=%0d wc=%0d done=0",
                     pkt_count[0], word_count[0], done[0], m_pkts, m_words);
        end
    endtask

    task automatic test_keep_mask();
        logic obs;
        bit   exp;
        m_select(0);
        do_start(0, 2'b10);
        beat_step(0, 1'b1, 32'hDEAD_BEEF, 4'b0101, 1'b1, obs, exp);
        do_read(0, 0);
        checks++;
        if (rd_data[0] !== m_ram[0][0][DW-1:0] || rd_keep[0] !== 4'b0101) begin
            failures++;
            $display("FAIL keep_mask got data=%h keep=%b exp data=%h keep=0101",
                     rd_data[0], rd_keep[0], m_ram[0][0][DW-1:0]);
        end
    endtask

    task automatic test_restart_and_reset();
        logic obs;
        bit   exp;
        m_select(0);
        do_start(0, 2'b10);
        beat_step(0, 1'b1, 32'hC0, 4'hF, 1'b0, obs, exp);
        beat_step(0, 1'b1, 32'hC1, 4'hF, 1'b0, obs, exp);
        // Beat coincident with a restart must vanish.
        @(negedge clk);
        tvalid[0] = 1'b1; tdata[0] = 32'hEE; tkeep[0] = 4'hF; tlast[0] = 1'b1;
        cfg_mode[0] = 2'b10; cfg_start[0] = 1'b1;
        @(posedge clk);
        m_clear(2);
        @(negedge clk);
        cfg_start[0] = 1'b0;
        tvalid[0] = 1'b0;
        checks++;
        if (word_count[0] !== 5'd0 || pkt_count[0] !== 16'd0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL restart_status wc=%0d pkt=%0d done=%b exp 0 0 0",
                     word_count[0], pkt_count[0], done[0]);
        end
        do_read(0, 0);
        checks++;
        if (rd_data[0] !== m_ram[0][0][DW-1:0]) begin
            failures++;
            $display("FAIL restart_mem0 got=%h exp=%h", rd_data[0], m_ram[0][0][DW-1:0]);
        end
        beat_step(0, 1'b1, 32'hD0, 4'hF, 1'b0, obs, exp);
        beat_step(0, 1'b1, 32'hD1, 4'hF, 1'b0, obs, exp);
        @(negedge clk);
        reset = 1'b0;
        m_clear(0);
        #1;
        checks++;
        if (tready[0] !== 1'b0 || word_count[0] !== 5'd0 || pkt_count[0] !== 16'd0 ||
            rd_data[0] !== '0) begin
            failures++;
            $display("FAIL async_reset tready=%b wc=%0d pkt=%0d rd=%h exp 0",
                     tready[0], word_count[0], pkt_count[0], rd_data[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tready[0] !== 1'b0 || word_count[0] !== 5'd0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL post_reset tready=%b wc=%0d done=%b exp 0",
                     tready[0], word_count[0], done[0]);
        end
        tvalid[0] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture_basic();
        test_capture_random();
        test_drop_full();
        test_sink();
        test_keep_mask();
        test_restart_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
